// File: rtl/sysarray_pkg.sv
// Shared definitions for the 3x3 systolic array feeder.
//   N         : array dimension
//   NN        : number of matrix elements (row-major flattening)
//   FEED_CYC  : length of the skewed feed window (3N-2 cycles)
//   T_W       : width of the feed-window counter
//   feeder_state_t : feeder FSM states
//   idx()     : row-major flattening helper, element (r,c) -> r*N+c
package sysarray_pkg;

  localparam int N        = 3;
  localparam int NN       = N * N;
  localparam int FEED_CYC = 3 * N - 2;
  localparam int T_W      = $clog2(FEED_CYC);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    WAIT,
    DONE
  } feeder_state_t;

  function automatic int idx(input int r, input int c);
    return r * N + c;
  endfunction

endpackage

// File: rtl/sysarray_feeder_if.sv
// Bus between the operand source/controller + array (master side) and the
// feeder (slave side).
//   start      : run request
//   a_mat      : matrix A, row-major, index 3*i+k
//   b_mat      : matrix B, row-major, index 3*k+j
//   acc_in     : array accumulator outputs, index 3*i+j
//   clr        : accumulator clear to the array
//   left / top : skewed row / column streams into the array
//   busy       : run in progress
//   res        : captured C = A*B
//   res_valid  : one-cycle pulse when res updates
interface sysarray_feeder_if
  import sysarray_pkg::*;
#(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int ACC_W = 18
) ();

  logic                    start;
  logic signed [A_W-1:0]   a_mat  [0:NN-1];
  logic signed [B_W-1:0]   b_mat  [0:NN-1];
  logic signed [ACC_W-1:0] acc_in [0:NN-1];
  logic                    clr;
  logic signed [A_W-1:0]   left   [0:N-1];
  logic signed [B_W-1:0]   top    [0:N-1];
  logic                    busy;
  logic signed [ACC_W-1:0] res    [0:NN-1];
  logic                    res_valid;

  modport slave (
    input  start, a_mat, b_mat, acc_in,
    output clr, left, top, busy, res, res_valid
  );

  modport master (
    output start, a_mat, b_mat, acc_in,
    input  clr, left, top, busy, res, res_valid
  );

endinterface

// File: rtl/sysarray_feeder.sv
// Transmit-side sequencer for the 3x3 signed systolic array.
// On an accepted start it latches A and B, pulses clr for one cycle, drives
// the skewed row/column streams for 3N-2 cycles, waits PE_LAT cycles for the
// last product to land, then captures acc_in into res and pulses res_valid.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : sysarray_feeder_if slave modport (see interface header)
module sysarray_feeder
  import sysarray_pkg::*;
#(
  parameter int A_W    = 8,
  parameter int B_W    = 8,
  parameter int ACC_W  = 18,
  parameter int PE_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  sysarray_feeder_if.slave bus
);

  localparam int W_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  feeder_state_t state, state_n;
  logic [T_W-1:0] t, t_n;
  logic [W_W-1:0] w, w_n;
  logic           accept;
  logic           cap;

  logic signed [A_W-1:0]   a_p0 [0:NN-1];
  logic signed [B_W-1:0]   b_p0 [0:NN-1];

  logic signed [A_W-1:0]   left_n  [0:N-1];
  logic signed [B_W-1:0]   top_n   [0:N-1];
  logic signed [A_W-1:0]   left_p1 [0:N-1];
  logic signed [B_W-1:0]   top_p1  [0:N-1];
  logic signed [ACC_W-1:0] res_p1  [0:NN-1];
  logic                    clr_p1;
  logic                    busy_p1;
  logic                    vld_p1;

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_n = state;
    t_n     = t;
    w_n     = w;
    accept  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_n = CLEAR;
          accept  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      CLEAR: begin
        state_n = FEED;
        t_n     = '0;
      end
      FEED: begin
        if (t == T_W'(FEED_CYC - 1)) begin
          state_n = WAIT;
          w_n     = '0;
        end else begin
          t_n = t + 1'b1;
        end
      end
      WAIT: begin
        if (w == W_W'(PE_LAT - 1)) state_n = DONE;
        else                       w_n = w + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign cap = (state == WAIT) && (w == W_W'(PE_LAT - 1));

  // Skew selection: row i carries A[i][t-i], column j carries B[t-j][j].
  // Lanes outside their 3-cycle window are driven to zero.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      left_n[i] = '0;
      top_n[i]  = '0;
      if (state_n == FEED) begin
        for (int k = 0; k < N; k++) begin
          if (t_n == T_W'(i + k)) begin
            left_n[i] = a_p0[idx(i, k)];
            top_n[i]  = b_p0[idx(k, i)];
          end
        end
      end
    end
  end

  // Stage p0: operand capture on an accepted start; held until the next one.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      for (int n = 0; n < NN; n++) begin
        a_p0[n] <= bus.a_mat[n];
        b_p0[n] <= bus.b_mat[n];
      end
    end
  end

  // Stage p1: state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      t       <= '0;
      w       <= '0;
      clr_p1  <= 1'b0;
      busy_p1 <= 1'b0;
      vld_p1  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        left_p1[i] <= '0;
        top_p1[i]  <= '0;
      end
      for (int n = 0; n < NN; n++) res_p1[n] <= '0;
    end else begin
      state   <= state_n;
      t       <= t_n;
      w       <= w_n;
      clr_p1  <= (state_n == CLEAR);
      busy_p1 <= (state_n inside {CLEAR, FEED, WAIT});
      vld_p1  <= (state_n == DONE);
      for (int i = 0; i < N; i++) begin
        left_p1[i] <= left_n[i];
        top_p1[i]  <= top_n[i];
      end
      if (cap) begin
        for (int n = 0; n < NN; n++) res_p1[n] <= bus.acc_in[n];
      end
    end
  end

  assign bus.clr       = clr_p1;
  assign bus.busy      = busy_p1;
  assign bus.res_valid = vld_p1;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign bus.left[i] = left_p1[i];
    assign bus.top[i]  = top_p1[i];
  end

  for (genvar n = 0; n < NN; n++) begin : g_res
    assign bus.res[n] = res_p1[n];
  end

endmodule
